// File: rtl/onehot_rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// onehot_rr_arbiter_8
// Round-robin arbiter that shares one 8-way resource between 8 requesters.
// The owner keeps the grant for as long as it requests. Fairness comes from a
// rotating priority pointer that moves to (owner + 1) whenever a grant ends.
// Exactly one dead cycle (grant = 0) separates two consecutive owners.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   Each owner is limited to MAX_HOLD consecutive grant cycles. A forced
//   release drops the grant and pulses timeout for one cycle.
//   Without the macro there is no hold counter and timeout stays 0.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (2..65535);
//             only used with ARB_TIMEOUT_EN
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req[7:0]   level-sensitive request vector, bit i = requester i
//   grant[7:0] registered one-hot grant, zero when the resource is free
//   grant_idx  encoded grant index; keeps the last owner while grant is zero
//   busy       high while grant is non-zero
//   timeout    one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module onehot_rr_arbiter_8 #(
   parameter int MAX_HOLD = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   // Reject an out-of-range hold limit at elaboration time.
   if ((MAX_HOLD < 2) || (MAX_HOLD > 65535)) begin : g_bad_max_hold
      $error("onehot_rr_arbiter_8: MAX_HOLD must be in 2..65535");
   end

   state_t     state_r;
   state_t     state_next_s;
   logic [2:0] ptr_r;
   logic [2:0] ptr_next_s;
   logic [7:0] grant_r;
   logic [7:0] grant_next_s;
   logic [2:0] idx_r;
   logic [2:0] idx_next_s;
   logic       busy_r;
   logic       busy_next_s;
   logic       timeout_r;
   logic       timeout_next_s;
   logic [2:0] winner_s;
   logic       owner_req_s;
   logic       force_rel_s;
   logic       release_s;

   // First set request bit searching ptr, ptr+1, ... with 3-bit wrap-around.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] w;
      logic [2:0] idx;
      logic       found;
      w     = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = p + 3'(i);
         if (!found && r[idx]) begin
            w     = idx;
            found = 1'b1;
         end else begin
            w     = w;
         end
      end
      return w;
   endfunction

   assign winner_s    = rr_pick(req, ptr_r);
   // In OWNED only the current owner's request bit matters.
   assign owner_req_s = req[idx_r];

`ifdef ARB_TIMEOUT_EN
   localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
   // Counter is cleared on the grant edge, so the owner has held the grant
   // for MAX_HOLD cycles when the counter reads MAX_HOLD-1.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;

   // A still-requesting owner at its limit is forced off; a voluntary drop wins.
   assign force_rel_s = (state_r == OWNED) && owner_req_s && (cnt_r == HOLD_LAST);

   // Hold counter next value: counts OWNED cycles, cleared otherwise.
   always_comb begin
      cnt_next_s = cnt_r;
      case (state_r)
         IDLE: begin
            cnt_next_s = {CNT_W{1'b0}};
         end
         OWNED: begin
            if (owner_req_s && !force_rel_s) begin
               cnt_next_s = cnt_r + CNT_W'(1);
            end else begin
               cnt_next_s = {CNT_W{1'b0}};
            end
         end
         default: begin
            cnt_next_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // Hold counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_next_s;
      end
   end
`else
   assign force_rel_s = 1'b0;
`endif

   assign release_s = (state_r == OWNED) && (!owner_req_s || force_rel_s);

   // State, pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         ptr_r     <= 3'd0;
         grant_r   <= 8'h00;
         idx_r     <= 3'd0;
         busy_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         ptr_r     <= ptr_next_s;
         grant_r   <= grant_next_s;
         idx_r     <= idx_next_s;
         busy_r    <= busy_next_s;
         timeout_r <= timeout_next_s;
      end
   end

   // Next state and priority pointer.
   always_comb begin
      state_next_s = state_r;
      ptr_next_s   = ptr_r;
      case (state_r)
         IDLE: begin
            if (req != 8'h00) begin
               state_next_s = OWNED;
            end else begin
               state_next_s = IDLE;
            end
         end
         OWNED: begin
            if (release_s) begin
               state_next_s = IDLE;
               ptr_next_s   = idx_r + 3'd1;
            end else begin
               state_next_s = OWNED;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      grant_next_s   = grant_r;
      idx_next_s     = idx_r;
      busy_next_s    = busy_r;
      timeout_next_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (req != 8'h00) begin
               grant_next_s = 8'h01 << winner_s;
               idx_next_s   = winner_s;
               busy_next_s  = 1'b1;
            end else begin
               grant_next_s = 8'h00;
               busy_next_s  = 1'b0;
            end
         end
         OWNED: begin
            if (release_s) begin
               grant_next_s   = 8'h00;
               busy_next_s    = 1'b0;
               timeout_next_s = force_rel_s;
            end else begin
               busy_next_s    = 1'b1;
            end
         end
         default: begin
            grant_next_s = 8'h00;
            busy_next_s  = 1'b0;
         end
      endcase
   end

   assign grant     = grant_r;
   assign grant_idx = idx_r;
   assign busy      = busy_r;
   assign timeout   = timeout_r;

endmodule

// File: tb/tb_onehot_rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// tb_onehot_rr_arbiter_8
// Directed scoreboard bench. The stimulus process drives one vector per clock
// and pushes the hand-computed outputs expected after that edge; a monitor
// pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_onehot_rr_arbiter_8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       busy;
   logic       timeout;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [7:0] g;
      logic [2:0] i;
      logic       b;
      logic       t;
      string      n;
   } exp_t;

   exp_t sb_q[$];

   onehot_rr_arbiter_8 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .grant     (grant),
      .grant_idx (grant_idx),
      .busy      (busy),
      .timeout   (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one vector, let one edge pass, queue the outputs expected after it.
   task automatic step(input logic r, input logic [7:0] q, input logic [7:0] eg,
                       input logic [2:0] ei, input logic eb, input logic et,
                       input string nm);
      exp_t e;
      rst = r;
      req = q;
      @(posedge clk);
      e.g = eg;
      e.i = ei;
      e.b = eb;
      e.t = et;
      e.n = nm;
      sb_q.push_back(e);
      #1;
   endtask

   // Monitor: compare DUT outputs against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (grant !== e.g || grant_idx !== e.i || busy !== e.b || timeout !== e.t) begin
               n_bad++;
               $display("FAIL %s: got grant=%h idx=%0d busy=%b timeout=%b, want grant=%h idx=%0d busy=%b timeout=%b",
                        e.n, grant, grant_idx, busy, timeout, e.g, e.i, e.b, e.t);
            end
         end
      end
   end

   initial begin
      logic [7:0] bit_v;
      int         wait_cnt;
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      req   = 8'h00;

      // Reset with everyone requesting, then the first grant goes to 0.
      step(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "reset_a");
      step(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "reset_b");
      step(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0, "first_grant");
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "first_release");   // ptr=1

      // Single request.
      step(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0, "single_grant");
      step(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0, "single_hold");
      step(1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0, "single_drop");     // ptr=5

      // Back to ptr=0, then full contention: hold 3 cycles, drop 1.
      step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "reset_c");
      for (int o = 0; o < 8; o++) begin
         bit_v = 8'h01 << o;
         step(1'b0, 8'hFF, bit_v, 3'(o), 1'b1, 1'b0, "rot_grant");
         step(1'b0, 8'hFF, bit_v, 3'(o), 1'b1, 1'b0, "rot_hold1");
         step(1'b0, 8'hFF, bit_v, 3'(o), 1'b1, 1'b0, "rot_hold2");
         step(1'b0, 8'hFF & ~bit_v, 8'h00, 3'(o), 1'b0, 1'b0, "rot_dead");
      end
      step(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0, "rot_wrap");
      step(1'b0, 8'hFE, 8'h00, 3'd0, 1'b0, 1'b0, "rot_wrap_rel");    // ptr=1

      // Wrap-around: ptr=6, search order 6,7,0 finds idx0 before idx5.
      step(1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0, "wrap_own5");
      step(1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0, "wrap_rel5");       // ptr=6
      step(1'b0, 8'h21, 8'h01, 3'd0, 1'b1, 1'b0, "wrap_pick0");
      step(1'b0, 8'h21, 8'h01, 3'd0, 1'b1, 1'b0, "wrap_hold0");
      step(1'b0, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0, "wrap_rel0");       // ptr=1
      step(1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0, "wrap_pick5");
      step(1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0, "wrap_rel5b");      // ptr=6

      // Reset mid-grant, then ptr=0 picks idx1 from 8'h0A.
      step(1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0, "mid_own3");
      step(1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0, "mid_hold3");
      step(1'b1, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0, "mid_reset");
      step(1'b0, 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0, "mid_pick1");
      step(1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0, "others_ignored");
      step(1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, "mid_rel1");        // ptr=2

      // Timeout with MAX_HOLD=4, then a voluntary drop exactly at the limit.
`ifdef ARB_TIMEOUT_EN
      step(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "to_own0_c1");
      step(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "to_own0_c2");
      step(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "to_own0_c3");
      step(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "to_own0_c4");
      step(1'b0, 8'h03, 8'h00, 3'd0, 1'b0, 1'b1, "to_forced");
      step(1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0, "to_own1_c1");
      step(1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0, "to_own1_c2");
      step(1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0, "to_own1_c3");
      step(1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0, "to_own1_c4");
      step(1'b0, 8'h01, 8'h00, 3'd1, 1'b0, 1'b0, "to_voluntary");
      step(1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, "to_idle");
`else
      for (int c = 0; c < 9; c++) begin
         step(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "nto_hold0");
      end
      step(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0, "nto_still0");
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "nto_rel0");
`endif

      // Drain the scoreboard within a bounded number of cycles.
      wait_cnt = 0;
      while (sb_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      @(posedge clk);
      if (sb_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
